// File: rtl/dp_mc_pkg.sv
// Shared helpers for the multi-channel data path: the deterministic mix level
// (rotate left by one, then invert the LSB) and its repeated chain.
package dp_mc_pkg;

  localparam int unsigned MAX_WIDTH      = 64;
  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_COMB_DEPTH = 3;

  typedef logic [MAX_WIDTH-1:0] lane_t;

  function automatic lane_t width_mask(input int unsigned w);
    lane_t m;
    m = '0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Lanes narrower than MAX_WIDTH ride in the low bits; w selects the ring size.
  function automatic lane_t mix_level(input lane_t x, input int unsigned w);
    lane_t m;
    lane_t v;
    lane_t r;
    m = width_mask(w);
    v = x & m;
    r = ((v << 1) | (v >> (w - 1))) & m;
    return r ^ lane_t'(1);
  endfunction

  function automatic lane_t mix_chain(input lane_t x, input int unsigned depth,
                                      input int unsigned w);
    lane_t y;
    y = x & width_mask(w);
    for (int unsigned i = 0; i < depth; i++) begin
      y = mix_level(y, w);
    end
    return y;
  endfunction

endpackage

// File: rtl/dp_mc_stage.sv
// One pipeline stage covering all lanes: optional per-lane mix chain followed
// by a register holding data, valid and the item's comb_en flag.
module dp_mc_stage
  import dp_mc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned COMB_DEPTH = DEF_COMB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic                    valid_i,
  input  logic                    comb_en_i,
  input  logic [NUM_CH*WIDTH-1:0] data_i,
  output logic                    valid_o,
  output logic                    comb_en_o,
  output logic [NUM_CH*WIDTH-1:0] data_o
);

  logic [NUM_CH*WIDTH-1:0] mixed;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_lane
      assign mixed[c*WIDTH +: WIDTH] =
        WIDTH'(mix_chain(lane_t'(data_i[c*WIDTH +: WIDTH]), COMB_DEPTH, WIDTH));
    end
  endgenerate

  // Bubbles still move data through; only valid-qualified data matters downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o   <= 1'b0;
      comb_en_o <= 1'b0;
      data_o    <= '0;
    end else if (advance) begin
      valid_o   <= valid_i;
      comb_en_o <= comb_en_i;
      data_o    <= comb_en_i ? mixed : data_i;
    end
  end

endmodule

// File: rtl/data_path_mc.sv
// Multi-lane data path: DATA_DEPTH stages with a global stall derived from the
// output handshake, plus a wrapping count of items delivered.
module data_path_mc
  import dp_mc_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned DATA_DEPTH = 4,
  parameter int unsigned COMB_DEPTH = DEF_COMB_DEPTH,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_comb_en,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]        out_count
);

  logic                                  stall;
  logic [DATA_DEPTH:0]                   valid_chain;
  logic [DATA_DEPTH:0]                   comb_chain;
  logic [DATA_DEPTH:0][NUM_CH*WIDTH-1:0] data_chain;
  logic                                  unused_last_comb_en;

  // Whole pipeline freezes together, so in_ready never waits on a register.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign valid_chain[0] = in_valid;
  assign comb_chain[0]  = in_comb_en;
  assign data_chain[0]  = in_data;

  genvar s;
  generate
    for (s = 0; s < DATA_DEPTH; s++) begin : g_stage
      dp_mc_stage #(
        .NUM_CH    (NUM_CH),
        .WIDTH     (WIDTH),
        .COMB_DEPTH(COMB_DEPTH)
      ) u_stage (
        .clk      (clk),
        .rst      (rst),
        .advance  (~stall),
        .valid_i  (valid_chain[s]),
        .comb_en_i(comb_chain[s]),
        .data_i   (data_chain[s]),
        .valid_o  (valid_chain[s+1]),
        .comb_en_o(comb_chain[s+1]),
        .data_o   (data_chain[s+1])
      );
    end
  endgenerate

  assign out_valid           = valid_chain[DATA_DEPTH];
  assign out_data            = data_chain[DATA_DEPTH];
  assign unused_last_comb_en = comb_chain[DATA_DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_count <= '0;
    end else if (out_valid && out_ready) begin
      out_count <= out_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_data_path_mc.sv
// Directed bench for data_path_mc: table of isolated items with hand-computed
// mix results, then bubble, backpressure, counter-wrap and async-reset sequences.
module tb_data_path_mc;

  localparam int NUM_CH     = 2;
  localparam int WIDTH      = 8;
  localparam int DATA_DEPTH = 2;
  localparam int COMB_DEPTH = 3;
  localparam int CNT_W      = 4;
  localparam int DW         = NUM_CH * WIDTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_comb_en = 1'b0;
  logic [DW-1:0]    in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic [CNT_W-1:0] out_count;

  int               nVectors = 0;
  int               nMiscompares = 0;
  logic [CNT_W-1:0] expCount = '0;

  typedef struct {
    string         name;
    logic [DW-1:0] data;
    logic          combEn;
    logic [DW-1:0] expected;
  } vec_t;

  vec_t vectors[7];
  logic bubblePat[6];

  data_path_mc #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .DATA_DEPTH(DATA_DEPTH),
    .COMB_DEPTH(COMB_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_comb_en(in_comb_en),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One isolated item: exact two-cycle latency, data, then the count bump.
  task automatic applyStimulus(input vec_t v);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_data    = v.data;
    in_comb_en = v.combEn;
    step();
    in_valid   = 1'b0;
    in_data    = '0;
    in_comb_en = 1'b0;
    checkOutput({v.name, "_early"}, 32'(out_valid), 32'd0);
    step();
    checkOutput({v.name, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({v.name, "_data"}, 32'(out_data), 32'(v.expected));
    step();
    expCount = expCount + 4'd1;
    checkOutput({v.name, "_count"}, 32'(out_count), 32'(expCount));
  endtask

  function automatic logic [DW-1:0] item(input int n);
    return {8'(8'h10 + n), 8'(n)};
  endfunction

  initial begin
    // Six mix levels per lane for comb_en=1 items, worked by hand.
    vectors[0] = '{"basic_mix",   16'hA500, 1'b1, 16'h563F};
    vectors[1] = '{"bypass",      16'hA500, 1'b0, 16'hA500};
    vectors[2] = '{"swap_lanes",  16'h00A5, 1'b1, 16'h3F56};
    vectors[3] = '{"ff_80",       16'hFF80, 1'b1, 16'hC01F};
    vectors[4] = '{"01_3c",       16'h013C, 1'b1, 16'h7F30};
    vectors[5] = '{"bypass2",     16'h3CFF, 1'b0, 16'h3CFF};
    vectors[6] = '{"80_01",       16'h8001, 1'b1, 16'h1F7F};
    bubblePat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    #2 rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(out_data), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_count", 32'(out_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int i = 0; i < 7; i++) applyStimulus(vectors[i]);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = bubblePat[i];
      in_data  = {8'hB0, 8'(i)};
      step();
      if (i >= 2 && bubblePat[i-2]) expCount = expCount + 4'd1;
      if (i >= 1)
        checkOutput($sformatf("bubble_valid_%0d", i), 32'(out_valid), 32'(bubblePat[i-1]));
    end
    in_valid = 1'b0;
    checkOutput("bubble_count", 32'(out_count), 32'(expCount));

    // Backpressure: two items fill the pipe, item 3 waits upstream during the stall.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = item(1);
    checkOutput("bp_ready_1", 32'(in_ready), 32'd1);
    step();
    in_data = item(2);
    checkOutput("bp_ready_2", 32'(in_ready), 32'd1);
    step();
    in_data = item(3);
    for (int h = 0; h < 5; h++) begin
      checkOutput($sformatf("bp_hold_ready_%0d", h), 32'(in_ready), 32'd0);
      checkOutput($sformatf("bp_hold_valid_%0d", h), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_hold_data_%0d", h), 32'(out_data), 32'(item(1)));
      step();
    end
    checkOutput("bp_hold_count", 32'(out_count), 32'(expCount));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = (k < 2);
      in_data  = item(3 + k);
      checkOutput($sformatf("bp_rel_valid_%0d", k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("bp_rel_data_%0d", k), 32'(out_data), 32'(item(k + 1)));
      step();
      expCount = expCount + 4'd1;
    end
    in_valid = 1'b0;
    checkOutput("bp_drained", 32'(out_valid), 32'd0);
    checkOutput("bp_count", 32'(out_count), 32'(expCount));

    // Seventeen back-to-back items walk the 4-bit counter through 15 -> 0 -> 1.
    for (int i = 0; i < 20; i++) begin
      in_valid = (i < 17);
      in_data  = {8'(i), 8'(i)};
      step();
      if (i >= 2 && i <= 18) expCount = expCount + 4'd1;
      checkOutput($sformatf("stream_valid_%0d", i), 32'(out_valid),
                  32'((i >= 1 && i <= 17) ? 1 : 0));
      if (i >= 1 && i <= 17)
        checkOutput($sformatf("stream_data_%0d", i), 32'(out_data), 32'({8'(i - 1), 8'(i - 1)}));
      checkOutput($sformatf("stream_count_%0d", i), 32'(out_count), 32'(expCount));
    end
    in_valid = 1'b0;

    in_valid   = 1'b1;
    in_comb_en = 1'b1;
    in_data    = 16'h1234;
    step();
    in_data = 16'h5678;
    step();
    in_data = 16'h9ABC;
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_out_count", 32'(out_count), 32'd0);
    checkOutput("arst_out_data", 32'(out_data), 32'd0);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid   = 1'b0;
    in_comb_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2 * DATA_DEPTH; i++) begin
      step();
      checkOutput($sformatf("post_rst_valid_%0d", i), 32'(out_valid), 32'd0);
      checkOutput($sformatf("post_rst_count_%0d", i), 32'(out_count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/data_path_mc.md
Name: data_path_mc

Overview:
- Parametrised multi-channel successor to the single-bit data_path timing-test block.
- Carries NUM_CH lanes of WIDTH bits through DATA_DEPTH register stages, each optionally preceded by a COMB_DEPTH-level deterministic logic chain.
- Adds valid/ready flow control, a per-item combinational-enable mode bit, and an output item counter.
- Sits between clock-domain-phase test partitions in the top-level timing designs, driven from clk or its inverted form.

Parameters:
- NUM_CH, 2, number of parallel lanes, ≥1.
- WIDTH, 8, bits per lane, ≥2.
- DATA_DEPTH, 4, register stages, ≥1.
- COMB_DEPTH, 3, mix levels per stage, ≥0. A value of 0 makes every stage a plain register.
- CNT_W, 16, width of the output item counter.

Ports:
- clk  input  1  Single clock; all state on rising edge.
- rst  input  1  Asynchronous, active-low reset (0 = reset).
- in_valid  input  1  Input item present.
- in_ready  output  1  Block accepts the item this cycle.
- in_comb_en  input  1  Per-item mode: 1 = apply mix chain in every stage, 0 = register only.
- in_data  input  NUM_CH*WIDTH  Lane c occupies bits [c*WIDTH +: WIDTH].
- out_valid  output  1  Output item present.
- out_ready  input  1  Sink accepts the output item.
- out_data  output  NUM_CH*WIDTH  Processed lanes.
- out_count  output  CNT_W  Number of items transferred out; wraps modulo 2^CNT_W.

Behaviour:
- Mix level on a WIDTH-bit value: x <- rotl1(x) ^ 1, i.e. rotate left by 1, then invert the LSB.
- Stage function:
  - Item comb_en = 1: apply mix COMB_DEPTH times, then register.
  - Item comb_en = 0: register unchanged.
  - Each lane is processed independently with an identical function.
- Each stage holds data, valid, and comb_en. The comb_en bit travels with the item.
- stall = out_valid & ~out_ready.
- When ~stall, all stages shift one position per cycle. Bubbles (valid = 0) shift too and are not collapsed.
- When stall, every stage holds its contents.
- in_ready = ~stall, purely combinational from out_valid and out_ready.
- Input accepted when in_valid & in_ready. Stage 0 loads valid = in_valid whenever ~stall, so a non-accepted cycle inserts a bubble.
- out_valid, out_data, and comb_en come from the last stage register.
- Latency: an item accepted in cycle t appears at out_valid in cycle t+DATA_DEPTH when there is no stall. Each stall cycle adds one cycle.
- out_count increments by 1 on each out_valid & out_ready. It wraps from 2^CNT_W-1 to 0.
- Reset (rst = 0, async):
  - All stage valids = 0.
  - All stage data = 0.
  - All comb_en = 0.
  - out_count = 0.
  - Outputs read out_valid = 0, out_data = 0, in_ready = 1.
- Reset mid-operation: in-flight items are discarded and no partial output is produced. Deassertion is synchronised externally; the block does no reset synchronisation.
- Simultaneous out_ready deassert and new input: the input is not accepted (in_ready = 0 in that cycle), and the upstream holds it.
- Full pipeline with out_ready = 1 sustains one item per cycle.
- Data registers may update on bubbles. Only valid-qualified data is defined at the output.

Decomposition:
- Package dp_mc_pkg contains:
  - function mix_level(logic [WIDTH-1:0]), generic via parameterised class or macro;
  - function mix_chain(x, depth);
  - localparam defaults for WIDTH, COMB_DEPTH.
- Sub-module dp_mc_stage: one register stage for all lanes.
  - Inputs: clk, rst, advance, valid_i, comb_en_i, data_i.
  - Outputs: registered valid_o, comb_en_o, data_o.
  - The mix chain is instantiated per lane inside the stage.
- The top generates DATA_DEPTH stages plus the stall logic and counter.

Test Plan:
1. Basic mix: NUM_CH=1, WIDTH=8, DATA_DEPTH=2, COMB_DEPTH=3; send 0x00 with comb_en=1, out_ready=1 -> out_valid exactly 2 cycles later with out_data=0x3F (stage 1 = 0x07); out_count=1.
2. Mode bypass and lane independence: NUM_CH=2, send {0xA5,0x00} with comb_en=0 -> out_data {0xA5,0x00} after DATA_DEPTH cycles. Same item with comb_en=1 -> per-lane results match the model mix_chain applied DATA_DEPTH times, with no cross-lane mixing.
3. Backpressure: fill the pipeline with items 1..4, hold out_ready=0 for 5 cycles -> in_ready=0, out_valid=1, out_data stable at item 1. Release -> items 1..4 appear on consecutive cycles, no loss or duplication.
4. Bubbles: in_valid pattern 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed by DATA_DEPTH; out_count=2.
5. Counter wrap: CNT_W=4, stream 17 items -> out_count goes 15 then 0 then 1.
6. Async reset mid-stream: assert rst=0 between clock edges with 3 items in flight -> out_valid=0 and out_count=0 immediately, before the next edge. After release, no stale item emerges within 2*DATA_DEPTH cycles.
